// File: rtl/ahb_lite_sub_mem_if.sv
// AHB-Lite signal bundle between a requester and the scratch-memory subordinate.
interface ahb_lite_sub_mem_if #(
  parameter int pAHB_ADDR_WIDTH  = 32,
  parameter int pAHB_DATA_WIDTH  = 32,
  parameter int pAHB_HRESP_WIDTH = 2
);
  logic                        I_hsel;
  logic [pAHB_ADDR_WIDTH-1:0]  I_haddr;
  logic [1:0]                  I_htrans;
  logic                        I_hwrite;
  logic [2:0]                  I_hsize;
  logic [2:0]                  I_hburst;
  logic [3:0]                  I_hprot;
  logic [pAHB_DATA_WIDTH-1:0]  I_hwdata;
  logic                        I_hready;
  logic                        O_hreadyout;
  logic [pAHB_HRESP_WIDTH-1:0] O_hresp;
  logic [pAHB_DATA_WIDTH-1:0]  O_hrdata;

  modport master (
    output I_hsel, I_haddr, I_htrans, I_hwrite, I_hsize, I_hburst, I_hprot,
           I_hwdata, I_hready,
    input  O_hreadyout, O_hresp, O_hrdata
  );

  modport slave (
    input  I_hsel, I_haddr, I_htrans, I_hwrite, I_hsize, I_hburst, I_hprot,
           I_hwdata, I_hready,
    output O_hreadyout, O_hresp, O_hrdata
  );
endinterface

// File: rtl/ahb_lite_sub_mem.sv
// AHB-Lite subordinate fronting a word-organised scratch memory with
// programmable data-phase wait states and two-cycle ERROR responses.
//
// state | meaning
// IDLE  | no data phase in flight, ready high
// WAIT  | OKAY transfer stalled while the wait counter runs down
// DATA  | OKAY data phase: reads drive hrdata, writes commit byte lanes
// ERR1  | first ERROR cycle, ready low
// ERR2  | second ERROR cycle, ready high, may accept the next transfer
module ahb_lite_sub_mem #(
  parameter int                         pAHB_ADDR_WIDTH  = 32,
  parameter int                         pAHB_DATA_WIDTH  = 32,
  parameter int                         pAHB_HRESP_WIDTH = 2,
  parameter int                         pDEPTH_WORDS     = 64,
  parameter logic [pAHB_ADDR_WIDTH-1:0] pBASE_ADDR       = '0,
  parameter int                         pWAIT_STATES     = 1
) (
  input logic               clk,
  input logic               rst,
  ahb_lite_sub_mem_if.slave bus
);
  localparam int IDX_W = $clog2(pDEPTH_WORDS);
  localparam logic [pAHB_ADDR_WIDTH-1:0] WIN_BYTES = pAHB_ADDR_WIDTH'(pDEPTH_WORDS * 4);
  localparam logic [2:0] WAIT_LOAD = 3'(pWAIT_STATES - 1);
  localparam bit HAS_WAIT = (pWAIT_STATES > 0);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t                     state_q, state_d;
  logic [2:0]                 wait_cnt_q, wait_cnt_d;
  logic [IDX_W-1:0]           idx_q;
  logic                       wr_q;
  logic [3:0]                 mask_q;
  logic [pAHB_DATA_WIDTH-1:0] rdata_q;
  logic [pAHB_DATA_WIDTH-1:0] mem [pDEPTH_WORDS];

  logic                       accept;
  logic                       launch_ok;
  logic                       borrow;
  logic [pAHB_ADDR_WIDTH-1:0] offset;
  logic                       addr_err, size_err, align_err, xfer_err;
  logic [3:0]                 lane_mask;
  logic                       rd_active, wr_commit;
  logic                       unused_bits;

  assign unused_bits = ^{bus.I_hburst, bus.I_hprot, offset[1:0]};

  assign accept = bus.I_hsel & bus.I_hready & bus.I_htrans[1];

  // Borrow out of the subtraction flags an address below the window base.
  assign {borrow, offset} = {1'b0, bus.I_haddr} - {1'b0, pBASE_ADDR};
  assign addr_err  = borrow | (offset >= WIN_BYTES);
  assign size_err  = bus.I_hsize > 3'b010;
  assign align_err = ((bus.I_hsize == 3'b001) & bus.I_haddr[0]) |
                     ((bus.I_hsize == 3'b010) & (bus.I_haddr[1:0] != 2'b00));
  assign xfer_err  = addr_err | size_err | align_err;

  always_comb begin
    lane_mask = 4'b0000;
    case (bus.I_hsize)
      3'b000:  lane_mask = 4'b0001 << bus.I_haddr[1:0];
      3'b001:  lane_mask = bus.I_haddr[1] ? 4'b1100 : 4'b0011;
      3'b010:  lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // IDLE, DATA and ERR2 all present ready high, so each can take a new transfer.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    launch_ok  = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (wait_cnt_q == 3'd0) state_d = S_DATA;
        else                    wait_cnt_d = wait_cnt_q - 3'd1;
      end
      S_ERR1: state_d = S_ERR2;
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          if (xfer_err) begin
            state_d = S_ERR1;
          end else begin
            launch_ok = 1'b1;
            if (HAS_WAIT) begin
              state_d    = S_WAIT;
              wait_cnt_d = WAIT_LOAD;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      wr_q   <= 1'b0;
      mask_q <= 4'b0000;
    end else if (launch_ok) begin
      idx_q  <= offset[IDX_W+1:2];
      wr_q   <= bus.I_hwrite;
      mask_q <= lane_mask;
    end
  end

  assign rd_active = (state_q == S_DATA) & ~wr_q;
  assign wr_commit = (state_q == S_DATA) & wr_q & ~rst;

  // Read data comes straight from the array so a write committed one cycle
  // earlier is already visible; the register only holds it afterwards.
  always_ff @(posedge clk) begin
    if (rst)            rdata_q <= '0;
    else if (rd_active) rdata_q <= mem[idx_q];
  end

  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int n = 0; n < 4; n++) begin
        if (mask_q[n]) mem[idx_q][8*n +: 8] <= bus.I_hwdata[8*n +: 8];
      end
    end
  end

  always_comb begin
    bus.O_hreadyout = ~((state_q == S_WAIT) | (state_q == S_ERR1));
    bus.O_hresp     = '0;
    bus.O_hresp[0]  = (state_q == S_ERR1) | (state_q == S_ERR2);
    bus.O_hrdata    = rd_active ? mem[idx_q] : rdata_q;
  end
endmodule

// File: tb/tb_ahb_lite_sub_mem.sv
// Directed scoreboard bench for ahb_lite_sub_mem at 1, 0 and 3 wait states.
module tb_ahb_lite_sub_mem;
  localparam int WS_TBL [3] = '{1, 0, 3};
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  active   = 2'd0;
  logic        hsel_d   = 1'b0;
  logic [31:0] haddr_d  = '0;
  logic [1:0]  htrans_d = T_IDLE;
  logic        hwrite_d = 1'b0;
  logic [2:0]  hsize_d  = 3'b010;
  logic [31:0] hwdata_d = '0;

  logic [2:0]        ready_v;
  logic [2:0][1:0]   resp_v;
  logic [2:0][31:0]  rdata_v;
  logic              obs_ready;
  logic [1:0]        obs_resp;
  logic [31:0]       obs_rdata;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_lite_sub_mem_if bus_i ();
    assign bus_i.I_hsel   = hsel_d && (active == 2'(g));
    assign bus_i.I_haddr  = haddr_d;
    assign bus_i.I_htrans = htrans_d;
    assign bus_i.I_hwrite = hwrite_d;
    assign bus_i.I_hsize  = hsize_d;
    assign bus_i.I_hburst = 3'b000;
    assign bus_i.I_hprot  = 4'b0011;
    assign bus_i.I_hwdata = hwdata_d;
    assign bus_i.I_hready = bus_i.O_hreadyout;
    assign ready_v[g]     = bus_i.O_hreadyout;
    assign resp_v[g]      = bus_i.O_hresp;
    assign rdata_v[g]     = bus_i.O_hrdata;

    ahb_lite_sub_mem #(.pWAIT_STATES(WS_TBL[g])) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_i)
    );
  end

  assign obs_ready = ready_v[active];
  assign obs_resp  = resp_v[active];
  assign obs_rdata = rdata_v[active];

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          id;
    logic [31:0] wdata;
    logic        err;
    int          waits;
    logic [31:0] rdata;
  } exp_t;

  req_t        req_q [$];
  exp_t        exp_q [$];
  logic [31:0] model [3][64];
  logic [31:0] last_rd [3];
  int          checks  = 0;
  int          errors  = 0;
  int          next_id = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                     input logic [1:0] trans, input logic [31:0] wdata);
    req_t r;
    r.addr = addr; r.wr = wr; r.size = size; r.trans = trans; r.wdata = wdata;
    req_q.push_back(r);
  endtask

  // Expected outcome of a transfer at the moment its address phase is accepted.
  function automatic exp_t expect_of(input req_t r);
    exp_t e;
    int   w;
    int   b;
    e.id    = next_id;
    next_id++;
    e.wdata = r.wdata;
    e.err   = (r.addr >= 32'd256) || (r.size > 3'd2) ||
              (r.size == 3'd1 && r.addr[0]) || (r.size == 3'd2 && r.addr[1:0] != 2'd0);
    e.waits = e.err ? 1 : WS_TBL[active];
    w       = int'(r.addr[7:2]);
    if (!e.err && r.wr) begin
      for (int k = 0; k < (1 << r.size); k++) begin
        b = int'(r.addr[1:0]) + k;
        model[active][w][8*b +: 8] = r.wdata[8*b +: 8];
      end
    end
    if (!e.err && !r.wr) last_rd[active] = model[active][w];
    e.rdata = last_rd[active];
    return e;
  endfunction

  // Drives queued requests back-to-back, honouring hready, and checks each
  // completed data phase against the scoreboard entry pushed at acceptance.
  task automatic run_queue(input int budget);
    int   cyc      = 0;
    int   waits    = 0;
    logic low_resp = 1'b0;
    exp_t cur;
    while ((req_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      if (req_q.size() > 0) begin
        hsel_d   = 1'b1;
        haddr_d  = req_q[0].addr;
        hwrite_d = req_q[0].wr;
        hsize_d  = req_q[0].size;
        htrans_d = req_q[0].trans;
      end else begin
        hsel_d   = 1'b0;
        htrans_d = T_IDLE;
      end
      hwdata_d = (exp_q.size() > 0) ? exp_q[0].wdata : 32'h0;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        if (!obs_ready) begin
          waits++;
          low_resp = low_resp | obs_resp[0];
        end else begin
          cur = exp_q.pop_front();
          chk($sformatf("t%0d_resp", cur.id), 32'(obs_resp), {31'b0, cur.err});
          chk($sformatf("t%0d_waits", cur.id), 32'(waits), 32'(cur.waits));
          chk($sformatf("t%0d_err1_resp", cur.id), {31'b0, low_resp}, {31'b0, cur.err});
          chk($sformatf("t%0d_rdata", cur.id), obs_rdata, cur.rdata);
          waits    = 0;
          low_resp = 1'b0;
        end
      end
      if (obs_ready && req_q.size() > 0) exp_q.push_back(expect_of(req_q.pop_front()));
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    assert (cyc < budget) else begin
      errors++;
      $error("FAIL run_timeout observed=%0d expected=<%0d", cyc, budget);
    end
    req_q.delete();
    exp_q.delete();
    hsel_d   = 1'b0;
    htrans_d = T_IDLE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 3; i++) last_rd[i] = 32'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, obs_ready}, 32'd1);
    chk("rst_resp", 32'(obs_resp), 32'd0);
    chk("rst_rdata", obs_rdata, 32'd0);
    @(posedge clk);
    #1;

    // One wait state: word write/read, lane merges, boundary and error cases.
    active = 2'd0;
    add(32'h10, 1'b1, 3'b010, T_NSEQ, 32'hDEAD_BEEF);
    add(32'h10, 1'b0, 3'b010, T_NSEQ, 32'h0);
    add(32'h10, 1'b1, 3'b010, T_NSEQ, 32'h1122_3344);
    add(32'h13, 1'b1, 3'b000, T_NSEQ, 32'hAA00_0000);
    add(32'h10, 1'b0, 3'b010, T_NSEQ, 32'h0);
    add(32'h12, 1'b1, 3'b001, T_NSEQ, 32'h5566_0000);
    add(32'h10, 1'b0, 3'b010, T_NSEQ, 32'h0);
    run_queue(100);

    add(32'hFC, 1'b1, 3'b010, T_NSEQ, 32'hFEED_FACE);
    add(32'hFC, 1'b0, 3'b010, T_NSEQ, 32'h0);
    add(32'h100, 1'b0, 3'b010, T_NSEQ, 32'h0);
    run_queue(50);

    add(32'h00, 1'b1, 3'b010, T_NSEQ, 32'h0BAD_F00D);
    add(32'h01, 1'b1, 3'b001, T_NSEQ, 32'hFFFF_FFFF);
    add(32'h00, 1'b1, 3'b011, T_NSEQ, 32'hFFFF_FFFF);
    add(32'h02, 1'b1, 3'b010, T_NSEQ, 32'hFFFF_FFFF);
    add(32'h00, 1'b0, 3'b010, T_NSEQ, 32'h0);
    run_queue(80);

    // Zero wait states: pipelined SEQ bursts, then write/read pairs.
    active = 2'd1;
    for (int i = 0; i < 4; i++)
      add(32'h20 + 32'(4*i), 1'b1, 3'b010, (i == 0) ? T_NSEQ : T_SEQ, 32'(i + 1));
    for (int i = 0; i < 4; i++)
      add(32'h20 + 32'(4*i), 1'b0, 3'b010, (i == 0) ? T_NSEQ : T_SEQ, 32'h0);
    run_queue(50);
    for (int i = 0; i < 4; i++) begin
      add(32'h20 + 32'(4*i), 1'b1, 3'b010, T_NSEQ, 32'h100 + 32'(i));
      add(32'h20 + 32'(4*i), 1'b0, 3'b010, T_NSEQ, 32'h0);
    end
    run_queue(50);

    // BUSY and deselected NONSEQ to an illegal address must not start a transfer.
    for (int i = 0; i < 2; i++) begin
      hsel_d   = (i == 0);
      htrans_d = (i == 0) ? T_BUSY : T_NSEQ;
      haddr_d  = 32'h300;
      hwrite_d = 1'b0;
      hsize_d  = 3'b010;
      @(posedge clk);
      #1;
      hsel_d   = 1'b0;
      htrans_d = T_IDLE;
      @(negedge clk);
      chk($sformatf("nodata%0d_ready", i), {31'b0, obs_ready}, 32'd1);
      chk($sformatf("nodata%0d_resp", i), 32'(obs_resp), 32'd0);
      @(posedge clk);
      #1;
    end

    // Three wait states: establish contents, then abort a write with reset.
    active = 2'd2;
    add(32'h30, 1'b1, 3'b010, T_NSEQ, 32'h1234_5678);
    add(32'h30, 1'b0, 3'b010, T_NSEQ, 32'h0);
    run_queue(50);

    hsel_d   = 1'b1;
    haddr_d  = 32'h30;
    hwrite_d = 1'b1;
    hsize_d  = 3'b010;
    htrans_d = T_NSEQ;
    hwdata_d = 32'h0;
    @(posedge clk);
    #1;
    hsel_d   = 1'b0;
    htrans_d = T_IDLE;
    hwdata_d = 32'hCAFE_F00D;
    @(negedge clk);
    chk("abort_wait_ready", {31'b0, obs_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) last_rd[i] = 32'h0;
    @(negedge clk);
    chk("abort_ready", {31'b0, obs_ready}, 32'd1);
    chk("abort_resp", 32'(obs_resp), 32'd0);
    chk("abort_rdata", obs_rdata, 32'd0);
    @(posedge clk);
    #1;
    add(32'h30, 1'b0, 3'b010, T_NSEQ, 32'h0);
    run_queue(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb_lite_sub_mem.md
Name: ahb_lite_sub_mem

Overview:
- AHB-Lite subordinate (responder) with a word-organised scratch memory, programmable wait states and ERROR responses.
- Sits on the system AHB fabric opposite the security module's AHB requester port. It terminates O_haddr/O_htrans/O_hwdata transactions and returns hrdata/hreadyout/hresp.
- Used as the boot-time mailbox/staging buffer for payloads moved by the bus translation path.

Parameters:
pAHB_ADDR_WIDTH, 32, address bus width
pAHB_DATA_WIDTH, 32, data bus width (fixed 32 for this block)
pAHB_HRESP_WIDTH, 2, response width; bit0 = ERROR, bit1 always 0
pDEPTH_WORDS, 64, memory depth in 32-bit words
pBASE_ADDR, 32'h0000_0000, byte base address of the window
pWAIT_STATES, 1, data-phase wait cycles inserted on every OKAY NONSEQ/SEQ transfer (0..7)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
I_hsel  input  1  subordinate select
I_haddr  input  pAHB_ADDR_WIDTH  address phase address
I_htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
I_hwrite  input  1  1 = write
I_hsize  input  3  000 byte, 001 half, 010 word; others illegal
I_hburst  input  3  accepted, not interpreted
I_hprot  input  4  accepted, not interpreted
I_hwdata  input  pAHB_DATA_WIDTH  write data (data phase)
I_hready  input  1  bus-wide transfer-complete
O_hreadyout  output  1  this subordinate's ready
O_hresp  output  pAHB_HRESP_WIDTH  response
O_hrdata  output  pAHB_DATA_WIDTH  read data

Behaviour:
- Reset (rst=1 at posedge): O_hreadyout=1, O_hresp=0, O_hrdata=0, FSM=IDLE. Memory contents are NOT cleared.
- Address phase accepted when I_hsel & I_hready & I_htrans[1]. Addr, write, size and byte-lane mask are registered.
- Accepted IDLE/BUSY, or I_hsel=0: no data phase. The next cycle shows hreadyout=1 and hresp=OKAY.
- Error check at acceptance. Any of the following gives an ERROR transfer:
  - offset = haddr - pBASE_ADDR is ≥ pDEPTH_WORDS*4 or negative;
  - hsize > 010;
  - misaligned: half with addr[0]=1, or word with addr[1:0]≠0.
- FSM states and transitions:
  - IDLE: on an OKAY accept go to WAIT if pWAIT_STATES>0, else DATA. On an error accept go to ERR1.
  - WAIT: hreadyout=0, hresp=0. A counter decrements from pWAIT_STATES-1. At 0, go to DATA.
  - DATA: hreadyout=1, hresp=0. Reads drive O_hrdata = mem[offset>>2] (full word, all lanes). Writes commit I_hwdata byte lanes per mask in this cycle (little-endian: lane n = addr[1:0]+n). A new accept in the same cycle is pipelined, giving the next state per IDLE rules; otherwise go to IDLE.
  - ERR1: hreadyout=0, hresp=01, then ERR2.
  - ERR2: hreadyout=1, hresp=01. Memory is untouched. A new accept in this cycle is processed per IDLE rules.
- O_hrdata holds its last value outside read DATA cycles. Write transfers do not change it.
- Read-after-write, back-to-back to the same word: the read returns the newly written data. The write commits in its DATA cycle, and the read samples memory in its own later DATA cycle.
- An accept with I_hready=1 while O_hreadyout=0 cannot occur from this slave. An accept qualified by another subordinate's hready is legal and is handled normally.
- Reset mid-WAIT or mid-ERR1 aborts the transfer. No memory write occurs; outputs take reset values next cycle.
- Latency: OKAY transfer completes pWAIT_STATES+1 cycles after the address phase; ERROR completes in 2.

Test Plan:
- Reset, then NONSEQ word write 0xDEADBEEF @ base+0x10, then NONSEQ word read @0x10, pWAIT_STATES=1 -> each data phase has exactly 1 cycle hreadyout=0; read returns 0xDEADBEEF, hresp=0.
- Byte write 0xAA @0x13 over word 0x11223344 -> read @0x10 returns 0xAA223344; halfword write 0x5566 @0x12 -> 0x55663344.
- Read @ base+pDEPTH_WORDS*4 -> cycle1 hreadyout=0,hresp=01; cycle2 hreadyout=1,hresp=01; hrdata unchanged.
- Halfword write @0x01 and hsize=011 -> ERROR two-cycle each; memory word @0x00 unchanged on readback.
- 4-beat SEQ burst writes 1,2,3,4 @0x20.. pipelined, then reads with pWAIT_STATES=0 -> zero wait states, data 1..4, each read directly after its write returns the new value.
- Assert rst during WAIT of write 0xCAFEF00D @0x30 (pWAIT_STATES=3) -> next cycle hreadyout=1, hresp=0; read @0x30 returns the prior contents.
